// File: rtl/alu_pkg.sv
// Shared constants for the ALU execute stage: one-hot op codes, opcode
// patterns, FSM states and flag bit positions.
package alu_pkg;

    localparam logic [6:0] OP_ADD = 7'b0000001;
    localparam logic [6:0] OP_SUB = 7'b0000010;
    localparam logic [6:0] OP_AND = 7'b0000100;
    localparam logic [6:0] OP_OR  = 7'b0001000;
    localparam logic [6:0] OP_NOT = 7'b0010000;
    localparam logic [6:0] OP_SHR = 7'b0100000;
    localparam logic [6:0] OP_SHL = 7'b1000000;

    // SUB matches on the top four opcode bits only; the rest are exact.
    localparam logic [3:0] OPC_SUB = 4'b1000;
    localparam logic [4:0] OPC_AND = 5'b10011;
    localparam logic [4:0] OPC_OR  = 5'b10010;
    localparam logic [4:0] OPC_NOT = 5'b10110;
    localparam logic [4:0] OPC_SHR = 5'b10101;
    localparam logic [4:0] OPC_SHL = 5'b10100;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode decode into the one-hot ALU op plus an illegal flag.
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [4:0] opcode,
    output logic [6:0] op_onehot,
    output logic       illegal
);

    always_comb begin
        op_onehot = '0;
        illegal   = 1'b0;
        if (opcode[4:1] == OPC_SUB) begin
            op_onehot = OP_SUB;
        end else if (opcode == OPC_AND) begin
            op_onehot = OP_AND;
        end else if (opcode == OPC_OR) begin
            op_onehot = OP_OR;
        end else if (opcode == OPC_NOT) begin
            op_onehot = OP_NOT;
        end else if (opcode == OPC_SHR) begin
            op_onehot = OP_SHR;
        end else if (opcode == OPC_SHL) begin
            op_onehot = OP_SHL;
        end else if (opcode[4] == 1'b0 ||
                     (opcode[4:3] == 2'b11 && opcode[2:0] != 3'b111)) begin
            // Both 00xxx and 01xxx fall into the ADD space.
            op_onehot = OP_ADD;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute stage: decodes the opcode, runs single-cycle ALU ops directly and
// shifts iteratively one bit per cycle, with registered result and flags.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int INSTR_W = 16,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [6:0]         op_onehot,
    output logic               illegal,
    output logic [2:0]         flags
);

    function automatic logic [2:0] mk_flags(input logic c, input logic [WIDTH-1:0] r);
        logic signed [WIDTH-1:0] rs;
        logic [2:0]              f;
        rs        = $signed(r);
        f         = '0;
        f[FLAG_C] = c;
        f[FLAG_N] = (rs < 0);
        f[FLAG_Z] = (r == '0);
        return f;
    endfunction

    logic [4:0]         opcode;
    logic [SHAMT_W-1:0] shamt;
    logic [6:0]         dec_onehot;
    logic               dec_illegal;
    logic               accept;
    logic               start_shift;
    logic               unused_instr;

    state_t             state_p0;
    logic [SHAMT_W-1:0] cnt_p0;
    logic [WIDTH-1:0]   work_p0;
    logic               dir_left_p0;

    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [WIDTH-1:0]   sh_next;
    logic               sh_out;

    assign opcode       = instr[INSTR_W-1 -: 5];
    assign shamt        = instr[SHAMT_W-1:0];
    assign unused_instr = ^instr[INSTR_W-6:SHAMT_W];

    alu_op_decoder u_dec (
        .opcode    (opcode),
        .op_onehot (dec_onehot),
        .illegal   (dec_illegal)
    );

    assign in_ready    = rst_n && (state_p0 == ST_IDLE) && (!out_valid || out_ready);
    assign accept      = in_valid && in_ready;
    assign start_shift = ((dec_onehot == OP_SHL) || (dec_onehot == OP_SHR)) &&
                         (shamt != '0);

    assign sum  = {1'b0, op_a} + {1'b0, op_b};
    assign diff = {1'b0, op_a} - {1'b0, op_b};

    // Single-cycle ops; a zero-amount shift passes op_a through with C clear.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        case (dec_onehot)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
            end
            OP_AND:         alu_res = op_a & op_b;
            OP_OR:          alu_res = op_a | op_b;
            OP_NOT:         alu_res = ~op_a;
            OP_SHR, OP_SHL: alu_res = op_a;
            default:        alu_res = '0;
        endcase
    end

    assign sh_next = dir_left_p0 ? {work_p0[WIDTH-2:0], 1'b0} : {1'b0, work_p0[WIDTH-1:1]};
    assign sh_out  = dir_left_p0 ? work_p0[WIDTH-1] : work_p0[0];

    // Shift working register carries data only, so it has no reset.
    always_ff @(posedge clk) begin
        if (state_p0 == ST_IDLE) begin
            if (accept && start_shift) begin
                work_p0 <= op_a;
            end
        end else begin
            work_p0 <= sh_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0    <= ST_IDLE;
            cnt_p0      <= '0;
            dir_left_p0 <= 1'b0;
            out_valid   <= 1'b0;
            result      <= '0;
            op_onehot   <= '0;
            illegal     <= 1'b0;
            flags       <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state_p0)
                ST_IDLE: begin
                    if (accept) begin
                        if (start_shift) begin
                            cnt_p0      <= shamt;
                            dir_left_p0 <= (dec_onehot == OP_SHL);
                            state_p0    <= ST_SHIFT;
                        end else begin
                            result    <= alu_res;
                            op_onehot <= dec_onehot;
                            illegal   <= dec_illegal;
                            out_valid <= 1'b1;
                            if (!dec_illegal) begin
                                flags <= mk_flags(alu_c, alu_res);
                            end
                        end
                    end
                end
                ST_SHIFT: begin
                    cnt_p0 <= cnt_p0 - 1'b1;
                    // Final step: the bit leaving now is the carry.
                    if (cnt_p0 == SHAMT_W'(1)) begin
                        result    <= sh_next;
                        op_onehot <= dir_left_p0 ? OP_SHL : OP_SHR;
                        illegal   <= 1'b0;
                        flags     <= mk_flags(sh_out, sh_next);
                        out_valid <= 1'b1;
                        state_p0  <= ST_IDLE;
                    end
                end
                default: state_p0 <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed scenarios plus randomized
// traffic under random backpressure, checked against a behavioural model.
module tb_alu_exec_unit;

    localparam int WIDTH   = 16;
    localparam int INSTR_W = 16;
    localparam int SHAMT_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] instr;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic [6:0]         op_onehot;
    logic               illegal;
    logic [2:0]         flags;

    alu_exec_unit #(.WIDTH(WIDTH), .INSTR_W(INSTR_W), .SHAMT_W(SHAMT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .op_onehot (op_onehot),
        .illegal   (illegal),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic [6:0]       oh;
        logic             ill;
        logic [2:0]       fl;
        int               due;
    } exp_t;

    exp_t       q[$];
    logic [2:0] mflags = 3'b000;
    int         vectors = 0;
    int         miscompares = 0;
    bit         rand_bp = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: opcode classes by pattern, arithmetic on wide integers.
    task automatic predict(input logic [INSTR_W-1:0] ins, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, output exp_t e, output int lat);
        logic [4:0]  o;
        int          k;
        int          kind;
        logic [31:0] wa;
        logic [31:0] wb;
        logic [31:0] r;
        logic        c;
        o    = ins[INSTR_W-1 -: 5];
        k    = int'(ins[SHAMT_W-1:0]);
        wa   = 32'(a);
        wb   = 32'(b);
        r    = '0;
        c    = 1'b0;
        lat  = 0;
        casez (o)
            5'b1000?: kind = 1;
            5'b10011: kind = 2;
            5'b10010: kind = 3;
            5'b10110: kind = 4;
            5'b10101: kind = 5;
            5'b10100: kind = 6;
            5'b00???: kind = 0;
            5'b01???: kind = 0;
            5'b11111: kind = -1;
            5'b11???: kind = 0;
            default:  kind = -1;
        endcase
        case (kind)
            0: begin r = wa + wb; c = r[WIDTH]; end
            1: begin r = wa - wb; c = (wa < wb); end
            2: r = wa & wb;
            3: r = wa | wb;
            4: r = ~wa;
            5: begin r = wa >> k; c = (k > 0) ? wa[k-1] : 1'b0; lat = k; end
            6: begin r = wa << k; c = (k > 0) ? wa[WIDTH-k] : 1'b0; lat = k; end
            default: r = '0;
        endcase
        e.res = r[WIDTH-1:0];
        e.oh  = (kind < 0) ? 7'd0 : 7'(1 << kind);
        e.ill = (kind < 0);
        if (kind >= 0) mflags = {c, r[WIDTH-1], (r[WIDTH-1:0] == '0)};
        e.fl  = mflags;
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input logic [INSTR_W-1:0] ins, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input bit expect_it);
        exp_t e;
        int   lat;
        int   waitc;
        waitc    = 0;
        instr    = ins;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready) begin
            waitc++;
            if (waitc > 200) begin
                chk("accept_timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        if (expect_it) begin
            predict(ins, a, b, e, lat);
            e.due = cyc + lat;
            q.push_back(e);
        end
    endtask

    always begin
        @(negedge clk);
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: latency on first appearance, stability while stalled, values on handshake.
    initial begin
        bit               pend;
        bit               holding;
        logic [WIDTH-1:0] h_res;
        logic [6:0]       h_oh;
        logic             h_ill;
        logic [2:0]       h_fl;
        pend    = 1'b0;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                pend    = 1'b0;
                holding = 1'b0;
                continue;
            end
            if (holding) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_result", 32'(result), 32'(h_res));
                chk("hold_onehot", 32'(op_onehot), 32'(h_oh));
                chk("hold_illegal", 32'(illegal), 32'(h_ill));
                chk("hold_flags", 32'(flags), 32'(h_fl));
                holding = 1'b0;
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!pend) begin
                        chk("latency", 32'(cyc), 32'(q[0].due));
                        pend = 1'b1;
                    end
                    if (out_ready) begin
                        chk("result", 32'(result), 32'(q[0].res));
                        chk("onehot", 32'(op_onehot), 32'(q[0].oh));
                        chk("illegal", 32'(illegal), 32'(q[0].ill));
                        chk("flags", 32'(flags), 32'(q[0].fl));
                        void'(q.pop_front());
                        pend = 1'b0;
                    end else begin
                        holding = 1'b1;
                        h_res   = result;
                        h_oh    = op_onehot;
                        h_ill   = illegal;
                        h_fl    = flags;
                    end
                end
            end
        end
    end

    initial begin
        logic [INSTR_W-1:0] ri;
        logic [WIDTH-1:0]   ra;
        logic [WIDTH-1:0]   rb;
        int                 drain;
        in_valid  = 1'b0;
        instr     = '0;
        op_a      = '0;
        op_b      = '0;
        out_ready = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_onehot", 32'(op_onehot), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_flags", 32'(flags), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("idle_in_ready", 32'(in_ready), 32'd1);

        // ADD wraps to zero with carry
        send(16'h0000, 16'hFFFF, 16'h0001, 1'b1);
        #3;
        chk("add_result", 32'(result), 32'h0000);
        chk("add_flags", 32'(flags), 32'b101);

        // SUB with borrow, then an illegal op leaves flags alone
        send(16'h8000, 16'h0003, 16'h0005, 1'b1);
        #3;
        chk("sub_result", 32'(result), 32'hFFFE);
        chk("sub_flags", 32'(flags), 32'b110);
        send(16'hF800, 16'h1234, 16'h5678, 1'b1);
        #3;
        chk("illegal_flag", 32'(illegal), 32'd1);
        chk("illegal_result", 32'(result), 32'h0000);
        chk("illegal_flags", 32'(flags), 32'b110);

        // SHL by 3: busy for three cycles
        @(negedge clk);
        send(16'hA003, 16'h9001, 16'h0000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1 chk("shift_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        #3;
        chk("shl_valid", 32'(out_valid), 32'd1);
        chk("shl_result", 32'(result), 32'h8008);
        chk("shl_onehot", 32'(op_onehot), 32'b1000000);
        chk("shl_flags", 32'(flags), 32'b010);

        // AND under backpressure; a competing request must be ignored
        @(negedge clk);
        out_ready = 1'b0;
        send(16'h9800, 16'hF0F0, 16'hFF00, 1'b1);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            instr    = 16'h0000;
            op_a     = 16'h0001;
            op_b     = 16'h0001;
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_result", 32'(result), 32'hF000);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1 chk("bp_release_in_ready", 32'(in_ready), 32'd1);

        // SHR aborted by reset
        @(negedge clk);
        send(16'hA80F, 16'hFFFF, 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_onehot", 32'(op_onehot), 32'd0);
        chk("abort_flags", 32'(flags), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd0);
        mflags = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("post_abort_valid", 32'(out_valid), 32'd0);
            chk("post_abort_in_ready", 32'(in_ready), 32'd1);
            @(negedge clk);
        end

        // Random traffic with random backpressure
        rand_bp = 1'b1;
        for (int n = 0; n < 300; n++) begin
            ri = INSTR_W'($urandom);
            case ($urandom_range(0, 5))
                0:       ra = '1;
                1:       ra = '0;
                default: ra = WIDTH'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0:       rb = '1;
                1:       rb = WIDTH'(1);
                default: rb = WIDTH'($urandom);
            endcase
            send(ri, ra, rb, 1'b1);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        rand_bp = 1'b0;
        #1 out_ready = 1'b1;
        drain = 0;
        while (q.size() != 0 && drain < 100) begin
            @(negedge clk);
            drain++;
        end
        repeat (2) @(negedge clk);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Parametrised execute stage that replaces the purely combinational ALU op decode. It decodes the instruction opcode into the 7-bit one-hot ALU op and executes the op on two WIDTH-bit operands. Shifts run iteratively, one bit per cycle, and the block keeps a registered flag set. It sits between register-read and writeback, with valid/ready handshakes on both sides.

Parameters:
WIDTH, 16, operand/result width (>=2)
INSTR_W, 16, instruction width (>=16); opcode is instr[INSTR_W-1:INSTR_W-5]
SHAMT_W, 4, shift-amount width; shamt = instr[SHAMT_W-1:0]

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid && in_ready
instr  in  INSTR_W  instruction
op_a  in  WIDTH  operand A (shift/NOT source)
op_b  in  WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer ready
result  out  WIDTH  registered result
op_onehot  out  7  decoded op: ADD=0000001 SUB=0000010 AND=0000100 OR=0001000 NOT=0010000 SHR=0100000 SHL=1000000
illegal  out  1  op did not decode
flags  out  3  {C,N,Z}, last legal completed op

Behaviour:
- Decode uses op = top 5 instruction bits o[4:0], with priority:
  - o[4:1]=1000 -> SUB
  - 10011 -> AND; 10010 -> OR; 10110 -> NOT; 10101 -> SHR; 10100 -> SHL
  - o[4:3]=00 or 01, or (o[4:3]=11 and o[2:0]!=111) -> ADD
  - otherwise op=0 and the op is illegal.
- Reset (async, rst_n=0): state IDLE; out_valid, result, op_onehot, illegal, flags and the internal count all 0; in_ready=0 while in reset.
- States:
  - IDLE: in_ready = !out_valid || out_ready.
  - SHIFT: in_ready=0.
- Accept in IDLE, non-shift op or shamt=0: result, op_onehot, illegal and flags are registered at that edge; out_valid=1 on the next cycle (latency 1).
- Accept, SHL/SHR with shamt=k>0:
  - Load the working register with op_a and the count with k; go to SHIFT.
  - Each SHIFT cycle shifts by 1 (logical, zero fill) and decrements the count.
  - On the cycle the count goes 1->0: register result, go to IDLE, out_valid visible next cycle. Latency is k+1.
  - If k >= WIDTH the result is 0 naturally.
- Arithmetic: all results are modulo 2^WIDTH.
  - ADD: C=carry out.
  - SUB: a-b, C=borrow (a<b unsigned).
  - SHL/SHR: C=last bit shifted out; shamt=0 gives result=a, C=0.
  - AND/OR/NOT: C=0.
  - N=result[WIDTH-1]; Z=(result==0).
- Illegal op: result=0, op_onehot=0, illegal=1, flags unchanged; still produces out_valid with latency 1.
- Output hold: while out_valid && !out_ready, result, op_onehot, illegal and flags stay stable.
- out_valid clears on handshake unless a new result is loaded at the same edge. Back-to-back accept and output handshake in one cycle are allowed.
- in_valid while in_ready=0 is ignored and has no side effect.
- Reset mid-SHIFT aborts the op: no out_valid after release, and the op is not replayed.

Decomposition:
- alu_pkg holds:
  - the seven one-hot op localparams
  - the opcode patterns (SUB 4-bit, others 5-bit)
  - the state enum (IDLE, SHIFT)
  - the flag bit indices C=2, N=1, Z=0.
- Sub-module alu_op_decoder: combinational. Input is the 5-bit opcode; outputs are op_onehot[6:0] and illegal. It is instantiated once inside alu_exec_unit.

Test Plan:
1. ADD: instr=16'h0000, a=FFFF, b=0001, out_ready=1 -> next cycle out_valid=1, result=0000, op_onehot=0000001, flags C=1 N=0 Z=1.
2. SUB: instr=16'h8000, a=0003, b=0005 -> latency 1, result=FFFE, op_onehot=0000010, C=1 N=1 Z=0.
3. SHL: instr=16'hA003 (shamt 3), a=9001, accepted at T:
   - in_ready=0 for T+1..T+3
   - out_valid at T+4, result=8008, op_onehot=1000000, C=0 N=1 Z=0.
4. Backpressure: AND instr=16'h9800, a=F0F0, b=FF00, out_ready=0 for 5 cycles:
   - result=F000 held stable, in_ready=0, a new in_valid is ignored
   - raising out_ready completes the handshake, with in_ready=1 that cycle.
5. Illegal: after test 2, instr=16'hF800 -> illegal=1, op_onehot=0, result=0, flags still C=1 N=1 Z=0.
6. Reset mid-shift: SHR instr=16'hA80F, a=FFFF; drive rst_n=0 two cycles after accept:
   - all outputs 0 immediately
   - after release, no out_valid and in_ready=1.
